// File: rtl/store_buffer.sv
// Posted-write store queue between the memory stage and the cache front-end.
// Loads have priority on the single SRAM port; queued stores drain whenever no load issues.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [1:0]             st_sz,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  output logic                   ld_stall,
  output logic                   sb_empty,
  output logic [$clog2(DEPTH):0] sb_count,
  output logic                   cache_re,
  output logic [31:0]            cache_raddr,
  output logic                   cache_we,
  output logic [31:0]            cache_waddr,
  output logic [31:0]            cache_wdata,
  output logic [1:0]             cache_access_sz,
  input  logic                   cache_hit
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       sz_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic not_full;
  logic enq;
  logic deq;
  logic buf_match;
  logic st_match;
  logic conflict;
  logic re_int;
  logic we_int;

  // Word-granular match against every live entry; byte offsets are ignored on purpose.
  always_comb begin
    buf_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == ld_addr[31:2])) begin
        buf_match = 1'b1;
      end
    end
  end

  // A store arriving alongside a load is older, so it must block the load too.
  assign st_match = st_valid & (st_addr[31:2] == ld_addr[31:2]);
  assign conflict = ~rst & ld_valid & (buf_match | st_match);
  assign re_int   = ~rst & ld_valid & ~conflict;
  assign we_int   = ~rst & (count != '0) & ~re_int;
  assign not_full = ~rst & (count < CW'(DEPTH));
  assign enq      = st_valid & not_full;
  assign deq      = we_int & cache_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // enq and deq never target the same slot: that needs the queue both empty and full.
      if (deq) begin
        valid_q[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        valid_q[wr_ptr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
      sz_q[wr_ptr]   <= st_sz;
    end
  end

  assign st_ready        = not_full;
  assign ld_stall        = conflict;
  assign cache_re        = re_int;
  assign cache_raddr     = ld_addr;
  assign cache_we        = we_int;
  assign cache_waddr     = we_int ? addr_q[rd_ptr] : 32'd0;
  assign cache_wdata     = we_int ? data_q[rd_ptr] : 32'd0;
  assign cache_access_sz = we_int ? sz_q[rd_ptr] : ACCESS_SZ_WORD;
  assign sb_empty        = rst | (count == '0);
  assign sb_count        = rst ? '0 : count;

endmodule

// File: tb/tb_store_buffer.sv
// Scenario bench for store_buffer: per-feature tasks plus a drain scoreboard.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_sz;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic        sb_empty;
  logic [2:0]  sb_count;
  logic        cache_re;
  logic [31:0] cache_raddr;
  logic        cache_we;
  logic [31:0] cache_waddr;
  logic [31:0] cache_wdata;
  logic [1:0]  cache_access_sz;
  logic        cache_hit;

  int total = 0;
  int bad = 0;
  int n_drained = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
  } sb_entry_t;

  sb_entry_t sb[$];

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_sz(st_sz),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
    .sb_empty(sb_empty), .sb_count(sb_count),
    .cache_re(cache_re), .cache_raddr(cache_raddr),
    .cache_we(cache_we), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .cache_access_sz(cache_access_sz), .cache_hit(cache_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: accepted stores are queued from the stimulus, drains are checked in order.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      total++;
      if (cache_re && cache_we) begin
        bad++;
        $display("FAIL port_exclusive got re=%b we=%b required not both", cache_re, cache_we);
      end
      if (cache_we && cache_hit) begin
        n_drained++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL drain_unexpected got addr=%h required no write", cache_waddr);
        end else begin
          sb_entry_t e;
          e = sb.pop_front();
          if ({cache_waddr, cache_wdata, cache_access_sz} !== {e.addr, e.data, e.sz}) begin
            bad++;
            $display("FAIL drain_order got %h/%h/%0d required %h/%h/%0d",
                     cache_waddr, cache_wdata, cache_access_sz, e.addr, e.data, e.sz);
          end
        end
      end
      if (st_valid && st_ready) begin
        sb.push_back('{addr: st_addr, data: st_data, sz: st_sz});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] sz, input logic lv, input logic [31:0] la,
                       input logic hit);
    st_valid  = sv;
    st_addr   = sa;
    st_data   = sd;
    st_sz     = sz;
    ld_valid  = lv;
    ld_addr   = la;
    cache_hit = hit;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 32'h4000_0000, 32'h1, SZ_BYTE, 1'b1, 32'h4000_0000, 1'b1);
    cyc();
    cyc();
    #3;
    total++;
    if ({st_ready, ld_stall, cache_re, cache_we, sb_empty, sb_count, cache_access_sz,
         cache_waddr, cache_wdata} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, SZ_WORD, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b stall=%b re=%b we=%b empty=%b cnt=%0d sz=%0d wa=%h wd=%h",
               st_ready, ld_stall, cache_re, cache_we, sb_empty, sb_count, cache_access_sz,
               cache_waddr, cache_wdata);
    end
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1);
    #3;
    total++;
    if ({st_ready, sb_empty, cache_we} !== 3'b110) begin
      bad++;
      $display("FAIL reset_release got rdy=%b empty=%b we=%b required 1 1 0", st_ready, sb_empty, cache_we);
    end
  endtask

  task automatic test_enqueue_drain();
    logic [31:0] a [3];
    logic [31:0] d [3];
    logic [1:0]  s [3];
    logic        exp_we;
    a = '{32'h1000, 32'h1004, 32'h1007};
    d = '{32'hDEAD_BEEF, 32'h1234, 32'hAB};
    s = '{SZ_WORD, SZ_HALF, SZ_BYTE};
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c <= 3) drive(1'b1, a[c-1], d[c-1], s[c-1], 1'b0, 32'd0, 1'b1);
      else        drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1);
      #3;
      exp_we = (c >= 2) && (c <= 4);
      total++;
      if (cache_we !== exp_we) begin
        bad++;
        $display("FAIL drain_we cycle%0d got %b required %b", c, cache_we, exp_we);
      end
      if (exp_we) begin
        total++;
        if ({cache_waddr, cache_access_sz} !== {a[c-2], s[c-2]}) begin
          bad++;
          $display("FAIL drain_head cycle%0d got %h/%0d required %h/%0d",
                   c, cache_waddr, cache_access_sz, a[c-2], s[c-2]);
        end
      end
      if (c == 5) begin
        total++;
        if (sb_empty !== 1'b1) begin
          bad++;
          $display("FAIL drain_empty got %b required 1", sb_empty);
        end
      end
    end
  endtask

  task automatic test_full();
    int start;
    int k;
    start = n_drained;
    for (int i = 0; i < 5; i++) begin
      cyc();
      drive(1'b1, 32'h5000 + i * 4, 32'hA0 + i, SZ_WORD, 1'b1, 32'h2000, 1'b1);
      #3;
      total++;
      if ({st_ready, cache_we, cache_re} !== {(i < 4), 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL full_ready store%0d got rdy=%b we=%b re=%b required rdy=%b we=0 re=1",
                 i, st_ready, cache_we, cache_re, (i < 4));
      end
    end
    total++;
    if (sb_count !== 3'd4) begin
      bad++;
      $display("FAIL full_count got %0d required 4", sb_count);
    end
    cyc();
    drive(1'b1, 32'h5010, 32'hA4, SZ_WORD, 1'b0, 32'd0, 1'b1);
    #3;
    total++;
    if ({st_ready, cache_we} !== 2'b01) begin
      bad++;
      $display("FAIL full_first_drain got rdy=%b we=%b required rdy=0 we=1", st_ready, cache_we);
    end
    cyc();
    #3;
    total++;
    if ({st_ready, sb_count} !== {1'b1, 3'd3}) begin
      bad++;
      $display("FAIL full_reopen got rdy=%b cnt=%0d required rdy=1 cnt=3", st_ready, sb_count);
    end
    cyc();
    drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1);
    k = 0;
    while (!sb_empty && k < 12) begin
      cyc();
      k++;
    end
    total++;
    if (!sb_empty) begin
      bad++;
      $display("FAIL full_drain_timeout got cnt=%0d required 0 within 12 cycles", sb_count);
    end
    total++;
    if (n_drained - start !== 5) begin
      bad++;
      $display("FAIL full_drain_total got %0d required 5", n_drained - start);
    end
  endtask

  task automatic test_conflict();
    cyc();
    drive(1'b1, 32'h3002, 32'h5555, SZ_HALF, 1'b0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b1, 32'h3000, (k == 2));
      #3;
      total++;
      if ({ld_stall, cache_re, cache_we} !== 3'b101) begin
        bad++;
        $display("FAIL conflict_stall cycle%0d got stall=%b re=%b we=%b required 1 0 1",
                 k, ld_stall, cache_re, cache_we);
      end
    end
    cyc();
    #3;
    total++;
    if ({ld_stall, cache_re, cache_we, cache_raddr} !== {3'b010, 32'h3000}) begin
      bad++;
      $display("FAIL conflict_release got stall=%b re=%b we=%b raddr=%h required 0 1 0 3000",
               ld_stall, cache_re, cache_we, cache_raddr);
    end
  endtask

  task automatic test_same_cycle();
    cyc();
    drive(1'b1, 32'h4000, 32'h7777, SZ_WORD, 1'b1, 32'h4000, 1'b1);
    #3;
    total++;
    if ({ld_stall, cache_re, cache_we, st_ready} !== 4'b1001) begin
      bad++;
      $display("FAIL same_cycle_stall got stall=%b re=%b we=%b rdy=%b required 1 0 0 1",
               ld_stall, cache_re, cache_we, st_ready);
    end
    cyc();
    drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b1, 32'h4000, 1'b1);
    #3;
    total++;
    if ({ld_stall, cache_we, cache_waddr} !== {2'b11, 32'h4000}) begin
      bad++;
      $display("FAIL same_cycle_drain got stall=%b we=%b waddr=%h required 1 1 4000",
               ld_stall, cache_we, cache_waddr);
    end
    cyc();
    #3;
    total++;
    if ({ld_stall, cache_re} !== 2'b01) begin
      bad++;
      $display("FAIL same_cycle_issue got stall=%b re=%b required 0 1", ld_stall, cache_re);
    end
  endtask

  task automatic test_hit_low();
    cyc();
    drive(1'b1, 32'h6000, 32'h11, SZ_WORD, 1'b0, 32'd0, 1'b0);
    cyc();
    drive(1'b1, 32'h6004, 32'h22, SZ_BYTE, 1'b0, 32'd0, 1'b0);
    #3;
    total++;
    if ({cache_we, cache_waddr, sb_count} !== {1'b1, 32'h6000, 3'd1}) begin
      bad++;
      $display("FAIL hit_low_first got we=%b waddr=%h cnt=%0d required 1 6000 1",
               cache_we, cache_waddr, sb_count);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, (k == 3));
      #3;
      total++;
      if ({cache_we, cache_waddr, cache_wdata, cache_access_sz, sb_count} !==
          {1'b1, 32'h6000, 32'h11, SZ_WORD, 3'd2}) begin
        bad++;
        $display("FAIL hit_low_hold cycle%0d got we=%b %h/%h/%0d cnt=%0d required 1 6000/11/2 cnt=2",
                 k, cache_we, cache_waddr, cache_wdata, cache_access_sz, sb_count);
      end
    end
    cyc();
    #3;
    total++;
    if ({cache_we, cache_waddr, cache_access_sz, sb_count} !== {1'b1, 32'h6004, SZ_BYTE, 3'd1}) begin
      bad++;
      $display("FAIL hit_low_advance got we=%b %h/%0d cnt=%0d required 1 6004/0 cnt=1",
               cache_we, cache_waddr, cache_access_sz, sb_count);
    end
    cyc();
    #3;
    total++;
    if (sb_empty !== 1'b1) begin
      bad++;
      $display("FAIL hit_low_empty got %b required 1", sb_empty);
    end
  endtask

  task automatic test_reset_wrap();
    for (int i = 0; i < 3; i++) begin
      cyc();
      drive(1'b1, 32'h7000 + i * 4, 32'hF0 + i, SZ_WORD, 1'b0, 32'd0, 1'b0);
    end
    cyc();
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1);
    #3;
    total++;
    if (cache_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_drain got we=%b required 0", cache_we);
    end
    cyc();
    rst = 1'b0;
    #3;
    total++;
    if ({cache_we, sb_count, sb_empty} !== {1'b0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL rst_discard got we=%b cnt=%0d empty=%b required 0 0 1", cache_we, sb_count, sb_empty);
    end
    for (int i = 0; i <= 10; i++) begin
      cyc();
      if (i < 10) drive(1'b1, 32'h8000 + i * 16, 32'hC0DE_0000 + i, 2'(i % 3), 1'b0, 32'd0, 1'b1);
      else        drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b1);
      #3;
      total++;
      if (i == 0) begin
        if (cache_we !== 1'b0) begin
          bad++;
          $display("FAIL wrap_first got we=%b required 0", cache_we);
        end
      end else if ({cache_we, cache_waddr, sb_count} !== {1'b1, 32'h8000 + (i - 1) * 16, 3'd1}) begin
        bad++;
        $display("FAIL wrap_pair%0d got we=%b waddr=%h cnt=%0d required 1 %h 1",
                 i, cache_we, cache_waddr, sb_count, 32'h8000 + (i - 1) * 16);
      end
    end
    cyc();
    #3;
    total++;
    if (sb_empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_empty got %b required 1", sb_empty);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, SZ_WORD, 1'b0, 32'd0, 1'b0);
    test_reset();
    test_enqueue_drain();
    test_full();
    test_conflict();
    test_same_cycle();
    test_hit_low();
    test_reset_wrap();
    cyc();
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL undrained got %0d entries required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write FIFO between the memory stage of the pipeline and the cache front-end. Stores are accepted in one cycle, held in a small in-order queue, and drained to the cache write port whenever the shared cache/SRAM port is not being used by a load. Loads bypass the queue to the cache read port. A load is stalled if its word address matches any buffered or incoming store, until the queue has drained that store.

## Interface
- `DEPTH`, 4: number of store entries; power of two, 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `st_valid`  in  1  the memory stage presents a store.
- `st_ready`  out  1  the store is accepted at this edge when `st_valid` is also high.
- `st_addr`  in  32  store byte address.
- `st_data`  in  32  store data, right-aligned (low bytes significant).
- `st_sz`  in  2  access size, using the shared `ACCESS_SZ_WORD`, `ACCESS_SZ_HALF` and `ACCESS_SZ_BYTE` encodings.
- `ld_valid`  in  1  the memory stage presents a load.
- `ld_addr`  in  32  load byte address.
- `ld_stall`  out  1  the load must be held; it is not issued to the cache this cycle.
- `sb_empty`  out  1  the queue holds no entries.
- `sb_count`  out  $clog2(DEPTH)+1  number of valid entries.
- `cache_re`  out  1  cache read enable.
- `cache_raddr`  out  32  cache read address; equals `ld_addr`.
- `cache_we`  out  1  cache write enable, driven by the queue head.
- `cache_waddr`  out  32  address of the head entry.
- `cache_wdata`  out  32  data of the head entry, unmodified (the cache does lane replication).
- `cache_access_sz`  out  2  `sz` of the head entry while `cache_we`=1; otherwise `ACCESS_SZ_WORD`.
- `cache_hit`  in  1  the cache completed the access this cycle.

## Operation
- Storage:
  - Circular array of `DEPTH` entries, each holding {addr, data, sz, valid}.
  - Head pointer `rd_ptr` and tail pointer `wr_ptr`, each $clog2(DEPTH) bits, wrapping modulo `DEPTH`.
  - Counter `count`, 0..DEPTH.
- Enqueue:
  - `st_ready` = (`count` < `DEPTH`).
  - There is no same-cycle pass-through when the queue is full, even if a dequeue happens that cycle.
  - On `st_valid` & `st_ready`: write the entry at `wr_ptr`, then `wr_ptr`++.
- Load conflict:
  - `conflict` = `ld_valid` & (some valid entry has addr[31:2] == `ld_addr`[31:2], or (`st_valid` & `st_addr`[31:2] == `ld_addr`[31:2])).
  - When `st_valid` and `ld_valid` are both high in the same cycle, the store is treated as older.
  - Matching is at word granularity; a partial-byte overlap still counts as a conflict.
- Port arbitration: the cache has a single SRAM address port, so read and write are mutually exclusive.
  - `cache_re` = `ld_valid` & !`conflict`. A load has priority.
  - `ld_stall` = `conflict`.
  - `cache_we` = (`count` > 0) & !`cache_re`. Drain happens in any cycle without an issued load, including stalled-load cycles.
  - `cache_re` & `cache_we` is never 1.
- Dequeue:
  - On `cache_we` & `cache_hit`: `rd_ptr`++ and the head entry's valid bit is cleared.
  - If `cache_hit`=0, the head is held and re-presented unchanged.
- Count update:
  - `count` += enqueue − dequeue.
  - Simultaneous enqueue and dequeue leave `count` unchanged.
  - On simultaneous enqueue and dequeue with `count`=1, the new entry becomes head on the next cycle.
- Ordering: stores drain strictly in acceptance order.
- `sb_empty` = (`count`==0); `sb_count` = `count`. Both are registered-state derived.

## Timing
- Reset:
  - While `rst`=1, all of these are forced to 0: `count`, both pointers, all valid bits, `st_ready`, `ld_stall`, `cache_re`, `cache_we`, `cache_waddr`, `cache_wdata`.
  - During reset, `sb_empty`=1 and `cache_access_sz`=`ACCESS_SZ_WORD`.
  - Reset asserted mid-drain discards all entries; no further writes are issued.
  - One cycle after `rst` falls, `st_ready`=1.
- Store acceptance: the earliest a store can reach the cache is the cycle after acceptance.
- Load outputs: `cache_re`, `cache_raddr` and `ld_stall` are combinational from the inputs and queue state, in the same cycle.
- Stall release: a conflicting load is released, with `ld_stall`=0 and `cache_re`=1, in the cycle after the last matching entry dequeues.
- Throughput:
  - With no loads and `cache_hit`=1, the queue drains one entry per cycle.
  - Continuous back-to-back loads starve the drain. This is accepted; the pipeline inserts bubbles when `st_ready`=0.

## Test plan
- Enqueue and drain:
  - Stimulus: reset, then three stores in consecutive cycles — 0x1000/word/0xDEADBEEF, 0x1004/half/0x1234, 0x1007/byte/0xAB — with no loads and `cache_hit`=1.
  - Required: `cache_we` high for cycles 2–4, with addresses 0x1000, 0x1004, 0x1007 in order and `sz` word, half, byte. `sb_empty` returns to 1 on cycle 5.
- Full queue:
  - Stimulus: hold `ld_valid`=1 to a non-conflicting address 0x2000 and issue 5 stores with `DEPTH`=4.
  - Required: `st_ready` drops after the 4th store, `sb_count`=4, `cache_we`=0 throughout. Dropping `ld_valid` drains the queue and `st_ready` rises after the first dequeue.
- Load conflict:
  - Stimulus: a store to 0x3002/half is buffered, then a load to 0x3000.
  - Required: `ld_stall`=1 and `cache_re`=0 until the store dequeues; the next cycle `cache_re`=1 and `cache_raddr`=0x3000.
- Same-cycle store and load:
  - Stimulus: with the queue empty, store 0x4000 and load 0x4000 in the same cycle.
  - Required: `ld_stall`=1 that cycle. The store drains the next cycle, and the load issues the cycle after.
- `cache_hit` low:
  - Stimulus: hold `cache_hit`=0 for 3 cycles with 2 entries queued.
  - Required: the head is re-presented unchanged and `sb_count` stays at 2; the pointer advances only after `cache_hit` rises.
- Reset and wrap-around:
  - Stimulus: assert `rst` with 3 entries queued.
  - Required: next cycle `cache_we`=0 and `sb_count`=0.
  - Then run 10 store/drain pairs; pointers wrap and the stores drain in order.
